// File: rtl/ts_sbox_accumulate.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ts_sbox_accumulate
// Purpose  : Downstream stage of the time-shared, masked PRINCE S-box.
//            Each beat delivers the 14 masked monomials of one subscript as
//            two independent shares. The monomials are registered before any
//            XOR combining, so the register acts as a glitch barrier. Each
//            share then goes through the S-box ANF, and the results are
//            accumulated over NUM_SUBSCRIPTS beats into a 2-share 4-bit
//            S-box output.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk             in   1   clock, rising edge
//   rst             in   1   asynchronous active-high reset
//   clear           in   1   synchronous abort of the partial accumulation
//   in_valid        in   1   a monomial beat is present
//   mono_share1     in  14   share-1 monomials, bit k-1 = monomial k
//                            (x y z w xy xz xw yz yw zw xyz xyw xzw yzw)
//   mono_share2     in  14   share-2 monomials, same packing
//   busy            out  1   evaluation in progress
//   beat_idx        out BW   index of the next expected beat
//   out_valid       out  1   one-cycle result strobe
//   sbox_out_share1 out  4   result share 1, bit 3 = MSB
//   sbox_out_share2 out  4   result share 2
// ----------------------------------------------------------------------------
// Build option:
//   TS_ACC_ZEROIZE_EN - when defined, the output shares, the monomial register
//                       and the accumulator are wiped once their contents have
//                       been used. When it is undefined, they hold their values.
// ============================================================================
module ts_sbox_accumulate #(
    parameter int          NUM_SUBSCRIPTS = 4,
    parameter logic [14:0] COEF_O1        = 15'h45A7,
    parameter logic [14:0] COEF_O2        = 15'h4B41,
    parameter logic [14:0] COEF_O3        = 15'h2CD2,
    parameter logic [14:0] COEF_O4        = 15'h712B,
    localparam int         BW             = (NUM_SUBSCRIPTS > 1) ? $clog2(NUM_SUBSCRIPTS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [13:0]   mono_share1,
    input  logic [13:0]   mono_share2,
    output logic          busy,
    output logic [BW-1:0] beat_idx,
    output logic          out_valid,
    output logic [3:0]    sbox_out_share1,
    output logic [3:0]    sbox_out_share2
);

    // Index 0 of the packed array holds the coefficients of output bit 1 (LSB).
    localparam logic [3:0][14:0] C_COEF      = {COEF_O4, COEF_O3, COEF_O2, COEF_O1};
    localparam logic [BW-1:0]    C_LAST_BEAT = BW'(NUM_SUBSCRIPTS - 1);
    localparam logic [BW-1:0]    C_ONE       = BW'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [BW-1:0] r_beat_idx;
    logic          w_accept;
    logic          w_in_last;

    // Stage 1: the monomial register, which is the glitch barrier.
    logic          r_s1_valid;
    logic [BW-1:0] r_s1_beat;
    logic [13:0]   r_m1;
    logic [13:0]   r_m2;

    // Stage 2: the accumulator.
    logic [3:0]    r_acc1;
    logic [3:0]    r_acc2;
    logic          r_done;
    logic          w_s1_first;
    logic          w_s1_last;
    logic [3:0]    w_p1;
    logic [3:0]    w_p2;

    // Output stage.
    logic          r_out_valid;
    logic [3:0]    r_out1;
    logic [3:0]    r_out2;

    // ANF of one share. The constant term is added only when asked for. The
    // caller asks for it on share 1, beat 0 only, so the constant is counted
    // exactly once across all shares and beats.
    function automatic logic [3:0] f_anf(input logic [13:0] m, input logic with_const);
        logic [3:0] p;
        p = '0;
        for (int j = 0; j < 4; j++) begin
            p[j] = (^(C_COEF[j][14:1] & m)) ^ (with_const & C_COEF[j][0]);
        end
        return p;
    endfunction

    assign w_accept  = in_valid & ~clear;
    assign w_in_last = (r_beat_idx == C_LAST_BEAT);

    // ------------------------------------------------------------------
    // Beat tracking FSM: the state register and the beat counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_beat_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (clear) begin
                r_beat_idx <= '0;
            end else if (w_accept) begin
                r_beat_idx <= w_in_last ? '0 : (r_beat_idx + C_ONE);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else if (w_accept) begin
            // The last beat returns the FSM to IDLE. With a single subscript,
            // every beat is the last one, so the FSM never leaves IDLE.
            w_state_nxt = w_in_last ? ST_IDLE : ST_ACCUM;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: capture the raw monomials. No XOR is applied before this
    // register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_beat  <= '0;
            r_m1       <= '0;
            r_m2       <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_m1      <= mono_share1;
                r_m2      <= mono_share2;
                r_s1_beat <= r_beat_idx;
            end
`ifdef TS_ACC_ZEROIZE_EN
            else if (r_s1_valid) begin
                // Stage 2 has consumed the contents on this edge.
                r_m1 <= '0;
                r_m2 <= '0;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: per-share ANF and accumulation. Each share uses only its own
    // bits.
    // ------------------------------------------------------------------
    assign w_s1_first = (r_s1_beat == '0);
    assign w_s1_last  = (r_s1_beat == C_LAST_BEAT);
    assign w_p1       = f_anf(r_m1, w_s1_first);
    assign w_p2       = f_anf(r_m2, 1'b0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc1 <= '0;
            r_acc2 <= '0;
            r_done <= 1'b0;
        end else if (clear) begin
            r_acc1 <= '0;
            r_acc2 <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= r_s1_valid & w_s1_last;
            if (r_s1_valid) begin
                r_acc1 <= w_s1_first ? w_p1 : (r_acc1 ^ w_p1);
                r_acc2 <= w_s1_first ? w_p2 : (r_acc2 ^ w_p2);
            end
`ifdef TS_ACC_ZEROIZE_EN
            else if (r_done) begin
                // The final value is handed to the output stage on this edge.
                r_acc1 <= '0;
                r_acc2 <= '0;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Output stage. A clear on this edge suppresses the pending strobe,
    // and the output shares keep their previous values.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out1      <= '0;
            r_out2      <= '0;
        end else begin
            r_out_valid <= r_done & ~clear;
            if (r_done & ~clear) begin
                r_out1 <= r_acc1;
                r_out2 <= r_acc2;
            end
`ifdef TS_ACC_ZEROIZE_EN
            else if (r_out_valid) begin
                r_out1 <= '0;
                r_out2 <= '0;
            end
`endif
        end
    end

    // Busy spans the first accepted beat up to the output strobe, and it
    // includes beats still in flight in the pipeline.
    assign busy            = (r_state == ST_ACCUM) | r_s1_valid | r_done;
    assign beat_idx        = r_beat_idx;
    assign out_valid       = r_out_valid;
    assign sbox_out_share1 = r_out1;
    assign sbox_out_share2 = r_out2;

endmodule
`default_nettype wire

// File: tb/tb_ts_sbox_accumulate.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ts_sbox_accumulate
// Purpose  : Self-checking bench for ts_sbox_accumulate (NUM_SUBSCRIPTS = 4).
//            Expected results come from the PRINCE S-box table and from an
//            ANF evaluation of the XOR-combined monomials of each share.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ts_sbox_accumulate;

    localparam int N  = 4;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          in_valid;
    logic [13:0]   mono_share1;
    logic [13:0]   mono_share2;
    logic          busy;
    logic [BW-1:0] beat_idx;
    logic          out_valid;
    logic [3:0]    sbox_out_share1;
    logic [3:0]    sbox_out_share2;

    int  checks = 0;
    int  errors = 0;
    time t_edge;

    logic [3:0]  sbox_tab [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                                   4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};
    logic [14:0] coefs [4]     = '{15'h45A7, 15'h4B41, 15'h2CD2, 15'h712B};

    ts_sbox_accumulate dut (
        .clk             (clk),
        .rst             (rst),
        .clear           (clear),
        .in_valid        (in_valid),
        .mono_share1     (mono_share1),
        .mono_share2     (mono_share2),
        .busy            (busy),
        .beat_idx        (beat_idx),
        .out_valid       (out_valid),
        .sbox_out_share1 (sbox_out_share1),
        .sbox_out_share2 (sbox_out_share2)
    );

    always #5 clk = ~clk;

    // The monomials of nibble v, with x = MSB and w = LSB.
    function automatic logic [13:0] monos(input logic [3:0] v);
        logic x, y, z, w;
        x = v[3]; y = v[2]; z = v[1]; w = v[0];
        return {y & z & w, x & z & w, x & y & w, x & y & z,
                z & w, y & w, y & z, x & w, x & z, x & y, w, z, y, x};
    endfunction

    // Evaluates the ANF polynomial on the combined monomial vector m.
    function automatic logic [3:0] anf(input logic [13:0] m, input bit addc);
        logic [3:0] r;
        for (int j = 0; j < 4; j++) begin
            bit b;
            b = addc ? coefs[j][0] : 1'b0;
            for (int k = 1; k <= 14; k++) begin
                if (coefs[j][k] && m[k-1]) b = ~b;
            end
            r[j] = b;
        end
        return r;
    endfunction

    task automatic send_beat(input logic [13:0] m1, input logic [13:0] m2);
        in_valid    = 1'b1;
        mono_share1 = m1;
        mono_share2 = m2;
        @(posedge clk);
        t_edge = $time;
        #1;
        in_valid    = 1'b0;
        mono_share1 = 14'($urandom);
        mono_share2 = 14'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits at most 12 cycles for out_valid. Samples on the falling edge.
    task automatic wait_out(output bit seen, output time t);
        seen = 0;
        t    = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                seen = 1;
                t    = $time;
                break;
            end
        end
    endtask

    task automatic run_eval(input logic [N-1:0][13:0] s1, input logic [N-1:0][13:0] s2,
                            input int maxgap, output bit seen, output time lat);
        time t;
        for (int b = 0; b < N; b++) begin
            if (b > 0 && maxgap > 0) idle(int'($urandom_range(maxgap, 0)));
            send_beat(s1[b], s2[b]);
        end
        wait_out(seen, t);
        lat = t - t_edge;
    endtask

    task automatic test_reset;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
        mono_share1 = '0; mono_share2 = '0;
        idle(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (beat_idx !== 2'd0) begin errors++; $display("FAIL reset_beat_idx: got %0d want 0", beat_idx); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if ({sbox_out_share1, sbox_out_share2} !== 8'h00) begin errors++; $display("FAIL reset_shares: got %h/%h want 0/0", sbox_out_share1, sbox_out_share2); end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_zero;
        bit seen; time lat;
        logic [3:0] h1, h2;
        run_eval('0, '0, 0, seen, lat);
        checks++; if (!seen) begin errors++; $display("FAIL zero_seen: out_valid never rose"); end
        checks++; if (lat != 25) begin errors++; $display("FAIL zero_latency: got %0t want 25", lat); end
        checks++; if (sbox_out_share1 !== 4'hB) begin errors++; $display("FAIL zero_share1: got %h want b", sbox_out_share1); end
        checks++; if (sbox_out_share2 !== 4'h0) begin errors++; $display("FAIL zero_share2: got %h want 0", sbox_out_share2); end
        h1 = sbox_out_share1; h2 = sbox_out_share2;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_pulse_width: got %b want 0", out_valid); end
`ifdef TS_ACC_ZEROIZE_EN
        h1 = 4'h0; h2 = 4'h0;
`endif
        checks++; if ({sbox_out_share1, sbox_out_share2} !== {h1, h2}) begin errors++; $display("FAIL zero_after_pulse: got %h/%h want %h/%h", sbox_out_share1, sbox_out_share2, h1, h2); end
    endtask

    task automatic test_all_ones;
        bit seen; time lat;
        logic [N-1:0][13:0] s1;
        s1 = '0; s1[0] = 14'h3FFF;
        run_eval(s1, '0, 0, seen, lat);
        checks++; if (!seen || lat != 25) begin errors++; $display("FAIL ones_timing: seen %0d latency %0t want 1/25", seen, lat); end
        checks++; if ((sbox_out_share1 ^ sbox_out_share2) !== 4'h4) begin errors++; $display("FAIL ones_value: got %h want 4", sbox_out_share1 ^ sbox_out_share2); end
    endtask

    task automatic test_input5;
        bit seen; time lat;
        logic [N-1:0][13:0] s1, s2;
        s1 = '0; s2 = '0;
        s1[0] = 14'h0002; s1[1] = 14'h0108;
        s2[0] = 14'h2A5B; s2[1] = 14'h2A5B;
        run_eval(s1, s2, 0, seen, lat);
        checks++; if (!seen || lat != 25) begin errors++; $display("FAIL in5_timing: seen %0d latency %0t want 1/25", seen, lat); end
        checks++; if ((sbox_out_share1 ^ sbox_out_share2) !== sbox_tab[5]) begin errors++; $display("FAIL in5_value: got %h want %h", sbox_out_share1 ^ sbox_out_share2, sbox_tab[5]); end
        checks++; if (sbox_out_share2 !== anf(14'h0, 1'b0)) begin errors++; $display("FAIL in5_share2: got %h want %h", sbox_out_share2, anf(14'h0, 1'b0)); end
    endtask

    task automatic test_random;
        for (int it = 0; it < 16; it++) begin
            bit seen; time lat;
            logic [3:0] nib;
            logic [N-1:0][13:0] s1, s2;
            logic [13:0] x1, x2;
            nib = 4'($urandom);
            x1 = '0; x2 = '0;
            for (int b = 0; b < N; b++) begin
                s1[b] = 14'($urandom); s2[b] = 14'($urandom);
                x2 ^= s2[b];
                if (b < N - 1) x1 ^= s1[b];
            end
            s1[N-1] = monos(nib) ^ x1 ^ x2;
            x1 ^= s1[N-1];
            run_eval(s1, s2, 2, seen, lat);
            checks++; if (!seen || lat != 25) begin errors++; $display("FAIL rand_timing it%0d: seen %0d latency %0t want 1/25", it, seen, lat); end
            checks++; if (sbox_out_share1 !== anf(x1, 1'b1)) begin errors++; $display("FAIL rand_share1 it%0d: got %h want %h", it, sbox_out_share1, anf(x1, 1'b1)); end
            checks++; if (sbox_out_share2 !== anf(x2, 1'b0)) begin errors++; $display("FAIL rand_share2 it%0d: got %h want %h", it, sbox_out_share2, anf(x2, 1'b0)); end
            checks++; if ((sbox_out_share1 ^ sbox_out_share2) !== sbox_tab[nib]) begin errors++; $display("FAIL rand_sbox it%0d: S(%h) got %h want %h", it, nib, sbox_out_share1 ^ sbox_out_share2, sbox_tab[nib]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] na, nb;
        logic [N-1:0][13:0] sa, sb;
        time ta, tb;
        int  npulse;
        time tp [4];
        logic [3:0] v1 [4], v2 [4];
        na = 4'($urandom); nb = 4'($urandom);
        sa = '0; sb = '0;
        sa[0] = monos(na); sb[0] = monos(nb);
        npulse = 0;
        fork
            begin
                for (int b = 0; b < N; b++) begin
                    if (b > 0) idle(1 + int'($urandom_range(2, 0)));
                    checks++; if (beat_idx !== BW'(b)) begin errors++; $display("FAIL b2b_idx_a%0d: got %0d want %0d", b, beat_idx, b); end
                    send_beat(sa[b], 14'h0);
                    if (b == 0) begin
                        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy); end
                    end
                end
                ta = t_edge;
                for (int b = 0; b < N; b++) begin
                    checks++; if (beat_idx !== BW'(b)) begin errors++; $display("FAIL b2b_idx_b%0d: got %0d want %0d", b, beat_idx, b); end
                    send_beat(sb[b], 14'h0);
                end
                tb = t_edge;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (out_valid === 1'b1 && npulse < 4) begin
                        tp[npulse] = $time;
                        v1[npulse] = sbox_out_share1;
                        v2[npulse] = sbox_out_share2;
                        npulse++;
                    end
                end
            end
        join
        checks++; if (npulse != 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", npulse); end
        if (npulse >= 2) begin
            checks++; if (tp[0] - ta != 25 || tp[1] - tb != 25) begin errors++; $display("FAIL b2b_latency: got %0t/%0t want 25/25", tp[0] - ta, tp[1] - tb); end
            checks++; if ((v1[0] ^ v2[0]) !== sbox_tab[na]) begin errors++; $display("FAIL b2b_value_a: got %h want %h", v1[0] ^ v2[0], sbox_tab[na]); end
            checks++; if ((v1[1] ^ v2[1]) !== sbox_tab[nb]) begin errors++; $display("FAIL b2b_value_b: got %h want %h", v1[1] ^ v2[1], sbox_tab[nb]); end
        end
    endtask

    task automatic test_clear;
        bit seen; time t, lat;
        logic [3:0] h1, h2;
        for (int b = 0; b < 3; b++) send_beat(14'($urandom), 14'($urandom));
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy_before: got %b want 1", busy); end
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        checks++; if (busy !== 1'b0 || beat_idx !== 2'd0) begin errors++; $display("FAIL clear_state: busy %b idx %0d want 0/0", busy, beat_idx); end
        wait_out(seen, t);
        checks++; if (seen) begin errors++; $display("FAIL clear_no_out: out_valid rose at %0t want none", t); end
        // A clear on the cycle after the last beat cancels the result already in flight.
        h1 = sbox_out_share1; h2 = sbox_out_share2;
        for (int b = 0; b < N; b++) send_beat(monos(4'h7), 14'h1234);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        wait_out(seen, t);
        checks++; if (seen) begin errors++; $display("FAIL clear_suppress: out_valid rose at %0t want none", t); end
        checks++; if ({sbox_out_share1, sbox_out_share2} !== {h1, h2}) begin errors++; $display("FAIL clear_hold: got %h/%h want %h/%h", sbox_out_share1, sbox_out_share2, h1, h2); end
        run_eval('0, '0, 0, seen, lat);
        checks++; if (!seen || lat != 25 || (sbox_out_share1 ^ sbox_out_share2) !== 4'hB) begin errors++; $display("FAIL clear_recover: seen %0d latency %0t value %h want 1/25/b", seen, lat, sbox_out_share1 ^ sbox_out_share2); end
    endtask

    task automatic test_async_reset;
        bit seen; time lat;
        for (int b = 0; b < 2; b++) send_beat(14'($urandom), 14'($urandom));
        #3;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || beat_idx !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL areset_ctrl: busy %b idx %0d ov %b want 0/0/0", busy, beat_idx, out_valid); end
        checks++; if ({sbox_out_share1, sbox_out_share2} !== 8'h00) begin errors++; $display("FAIL areset_shares: got %h/%h want 0/0", sbox_out_share1, sbox_out_share2); end
        idle(1);
        rst = 1'b0;
        run_eval('0, '0, 0, seen, lat);
        checks++; if (!seen || lat != 25 || sbox_out_share1 !== 4'hB || sbox_out_share2 !== 4'h0) begin errors++; $display("FAIL areset_recover: seen %0d latency %0t got %h/%h want 1/25/b/0", seen, lat, sbox_out_share1, sbox_out_share2); end
    endtask

    initial begin
        test_reset;
        test_zero;
        test_all_ones;
        test_input5;
        test_random;
        test_back_to_back;
        test_zero;
        test_clear;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
